// File: rtl/multicycle_adder_sub.sv
// Sequential add/subtract unit: WIDTH-bit operands summed DIGIT bits per clock through a
// registered carry, driven by a START/DONE handshake.
module multicycle_adder_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("multicycle_adder_sub: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   dig_sum;
  logic             msb_cin;
  logic             last_step;

  // One digit slice of the adder; the carry into the digit's top bit is recovered as a^b^sum.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_dig = a_q[i*DIGIT +: DIGIT];
        b_dig = b_q[i*DIGIT +: DIGIT];
      end
    end
    dig_sum   = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    msb_cin   = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dig_sum[DIGIT-1];
    last_step = (cnt_q == CNT_W'(N - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        // Subtraction is A + ~B + ~borrow, so COUT=1 means no borrow.
        if (START) begin
          a_d     = A;
          b_d     = SUB ? ~B : B;
          carry_d = SUB ? ~CIN : CIN;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < N; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            sum_d[i*DIGIT +: DIGIT] = dig_sum[DIGIT-1:0];
          end
        end
        carry_d = dig_sum[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (last_step) begin
          cout_d  = dig_sum[DIGIT];
          ovf_d   = msb_cin ^ dig_sum[DIGIT];
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign BUSY = (state_q != S_IDLE);
  assign DONE = (state_q == S_DONE);
  assign SUM  = sum_q;
  assign COUT = cout_q;
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_multicycle_adder_sub.sv
// Bench for multicycle_adder_sub: directed 8-bit vectors plus 16-bit DIGIT=1/4/16 instances
// checked against an arithmetic reference.
module tb_multicycle_adder_sub;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       rst, start, cin, sub;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;

  logic        start16, cin16, sub16;
  logic [15:0] a16, b16;
  logic [2:0]  busy16, done16, cout16, ovf16;
  logic [15:0] sum16 [3];

  multicycle_adder_sub #(.WIDTH(8), .DIGIT(2)) dut (
    .CLK(CLK), .RST(rst), .START(start), .A(a), .B(b), .CIN(cin), .SUB(sub),
    .BUSY(busy), .DONE(done), .SUM(sum), .COUT(cout), .OVF(ovf)
  );

  multicycle_adder_sub #(.WIDTH(16), .DIGIT(1)) dut_d1 (
    .CLK(CLK), .RST(rst), .START(start16), .A(a16), .B(b16), .CIN(cin16), .SUB(sub16),
    .BUSY(busy16[0]), .DONE(done16[0]), .SUM(sum16[0]), .COUT(cout16[0]), .OVF(ovf16[0])
  );

  multicycle_adder_sub #(.WIDTH(16), .DIGIT(4)) dut_d4 (
    .CLK(CLK), .RST(rst), .START(start16), .A(a16), .B(b16), .CIN(cin16), .SUB(sub16),
    .BUSY(busy16[1]), .DONE(done16[1]), .SUM(sum16[1]), .COUT(cout16[1]), .OVF(ovf16[1])
  );

  multicycle_adder_sub #(.WIDTH(16), .DIGIT(16)) dut_d16 (
    .CLK(CLK), .RST(rst), .START(start16), .A(a16), .B(b16), .CIN(cin16), .SUB(sub16),
    .BUSY(busy16[2]), .DONE(done16[2]), .SUM(sum16[2]), .COUT(cout16[2]), .OVF(ovf16[2])
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one op on the 8-bit unit, scramble the inputs after accept, and count edges to DONE.
  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                               input logic ts, output int lat);
    @(negedge CLK);
    a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
    @(posedge CLK); #1;
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    @(negedge CLK);
    start = 1'b0; a = ~ta; b = ~tb; cin = ~tc; sub = ~ts;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        vecs [12];
    int          lat, gap, cyc;
    logic [7:0]  held;
    logic        seen_done;
    logic [2:0]  seen;
    int          lat16 [3];
    logic [17:0] res16 [3];
    logic [15:0] beff;
    logic        ci;
    logic [16:0] full;
    logic        ovf_e;
    int          exp_lat [3];

    vecs[0]  = '{8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
    vecs[1]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5]  = '{8'h10, 8'h00, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0};
    vecs[6]  = '{8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[8]  = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[9]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0};
    vecs[11] = '{8'hA5, 8'h5A, 1'b1, 1'b1, 8'h4A, 1'b1, 1'b1};
    exp_lat = '{17, 5, 2};

    // Reset held two cycles with START asserted and noisy operands.
    rst = 1'b1; start = 1'b1; a = 8'($urandom); b = 8'($urandom); cin = 1'b1; sub = 1'b0;
    start16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'b1; sub16 = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_sum", 32'(sum), 32'h00);
    checkOutput("reset_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    checkOutput("reset_busy_done", {30'd0, busy, done}, 32'd0);
    checkOutput("reset_busy16", 32'(busy16), 32'd0);
    @(negedge CLK);
    rst = 1'b0; start = 1'b0; start16 = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
      checkOutput("idle_quiet", {30'd0, busy, done}, 32'd0);
    end

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
      checkOutput($sformatf("latency_v%0d", i), 32'(lat), 32'd5);
      checkOutput($sformatf("sum_v%0d", i), 32'(sum), 32'(vecs[i].sum));
      checkOutput($sformatf("cout_ovf_v%0d", i), {30'd0, cout, ovf},
                  {30'd0, vecs[i].cout, vecs[i].ovf});
      held = vecs[i].sum;
      @(posedge CLK); #1;
      checkOutput($sformatf("done_pulse_v%0d", i), 32'(done), 32'd0);
      checkOutput($sformatf("sum_held_v%0d", i), 32'(sum), 32'(held));
    end

    // START held high with operands changing every cycle while busy.
    @(negedge CLK);
    start = 1'b1; a = 8'h3C; b = 8'h05; cin = 1'b0; sub = 1'b0;
    @(posedge CLK); #1;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge CLK);
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      @(posedge CLK); #1;
      lat++;
    end
    checkOutput("held_start_latency", 32'(lat), 32'd5);
    checkOutput("held_start_result", {22'd0, cout, ovf, sum}, {22'd0, 1'b0, 1'b0, 8'h41});
    @(negedge CLK);
    a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0;
    gap = 0;
    do begin
      @(posedge CLK); #1;
      gap++;
    end while (done !== 1'b1 && gap < 40);
    checkOutput("back_to_back_spacing", 32'(gap), 32'd6);
    checkOutput("back_to_back_result", 32'(sum), 32'h03);
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(posedge CLK);

    // Reset asserted while the step counter sits at 2.
    @(negedge CLK);
    start = 1'b1; a = 8'h3C; b = 8'h05; cin = 1'b0; sub = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    rst = 1'b1;
    @(posedge CLK); #1;
    checkOutput("midrun_reset_outputs", {21'd0, busy, done, cout, ovf, sum}, 32'd0);
    @(negedge CLK);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (8) begin
      @(posedge CLK); #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    checkOutput("midrun_reset_no_done", 32'(seen_done), 32'd0);

    // 16-bit units with DIGIT=1, 4, 16 against an arithmetic reference.
    for (int k = 0; k < 1000; k++) begin
      @(negedge CLK);
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'($urandom);
      start16 = 1'b1;
      beff  = sub16 ? ~b16 : b16;
      ci    = sub16 ? ~cin16 : cin16;
      full  = {1'b0, a16} + {1'b0, beff} + 17'(ci);
      ovf_e = (a16[15] == beff[15]) && (full[15] != a16[15]);
      @(posedge CLK); #1;
      @(negedge CLK);
      start16 = 1'b0;
      seen = 3'b000;
      lat16 = '{0, 0, 0};
      res16 = '{18'd0, 18'd0, 18'd0};
      cyc = 1;
      while (seen != 3'b111 && cyc < 40) begin
        @(posedge CLK); #1;
        cyc++;
        for (int g = 0; g < 3; g++) begin
          if (!seen[g] && done16[g] === 1'b1) begin
            seen[g]  = 1'b1;
            lat16[g] = cyc;
            res16[g] = {cout16[g], ovf16[g], sum16[g]};
          end
        end
      end
      for (int g = 0; g < 3; g++) begin
        checkOutput($sformatf("w16_latency_g%0d_op%0d", g, k), 32'(lat16[g]), 32'(exp_lat[g]));
        checkOutput($sformatf("w16_result_g%0d_op%0d", g, k), 32'(res16[g]),
                    32'({full[16], ovf_e, full[15:0]}));
      end
      @(posedge CLK);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
